// File: rtl/bist_controller.sv
// BIST engine: LFSR pattern source, MISR response compactor and signature compare,
// with a pass-through of chip PIs to the CUT in system mode.
module bist_controller #(
    parameter int unsigned         PI_W       = 35,
    parameter int unsigned         PO_W       = 49,
    parameter int unsigned         N_PATTERNS = 2000,
    parameter logic [PI_W-1:0]     SEED       = 35'h1,
    parameter logic [PO_W-1:0]     GOLDEN_SIG = 49'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bistmode,
    input  logic [PI_W-1:0] pi,
    input  logic [PO_W-1:0] cut_po,
    output logic [PI_W-1:0] cut_pi,
    output logic            bistdone,
    output logic            bistpass
);

    localparam int unsigned CNT_W = $clog2(N_PATTERNS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PI_W-1:0] lfsr;
    logic [PO_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic [PI_W-1:0] lfsr_next;
    logic [PO_W-1:0] m_next;

    // x^35+x^2+1 LFSR and x^49+x^9+1 MISR next-state functions
    always_comb begin
        lfsr_next    = {lfsr[PI_W-2:0], lfsr[PI_W-1] ^ lfsr[1]};
        m_next       = {misr[PO_W-2:0], misr[PO_W-1]} ^ cut_po;
        m_next[9]    = m_next[9] ^ misr[PO_W-1];
    end

    assign cut_pi = (state == IDLE) ? pi : lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            misr     <= '0;
            cnt      <= '0;
            bistdone <= 1'b0;
            bistpass <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bistmode)
                        state <= RUN;
                end
                RUN: begin
                    if (!bistmode) begin
                        state <= IDLE;
                        lfsr  <= SEED;
                        misr  <= '0;
                        cnt   <= '0;
                    end else begin
                        lfsr <= lfsr_next;
                        misr <= m_next;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state    <= DONE;
                            bistdone <= 1'b1;
                            bistpass <= (m_next == GOLDEN_SIG);
                        end
                    end
                end
                DONE: begin
                    if (!bistmode) begin
                        state    <= IDLE;
                        lfsr     <= SEED;
                        misr     <= '0;
                        cnt      <= '0;
                        bistdone <= 1'b0;
                        bistpass <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lfsr     <= SEED;
                    misr     <= '0;
                    cnt      <= '0;
                    bistdone <= 1'b0;
                    bistpass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with an 8-pattern run length.
module tb_bist_controller;

    localparam int unsigned PI_W = 35;
    localparam int unsigned PO_W = 49;
    localparam int unsigned NP   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            bistmode;
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] cut_po;
    logic [PI_W-1:0] cut_pi;
    logic            bistdone;
    logic            bistpass;

    int errors = 0;
    int checks = 0;

    // Hand-computed LFSR states from SEED=1 with lfsr_next = {lfsr[33:0], lfsr[34]^lfsr[1]}
    logic [PI_W-1:0] seq [NP+1];

    bist_controller #(
        .PI_W(PI_W),
        .PO_W(PO_W),
        .N_PATTERNS(NP),
        .SEED(35'h1),
        .GOLDEN_SIG(49'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bistmode(bistmode),
        .pi(pi),
        .cut_po(cut_po),
        .cut_pi(cut_pi),
        .bistdone(bistdone),
        .bistpass(bistpass)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PO_W-1:0] misr_step(input logic [PO_W-1:0] m, input logic [PO_W-1:0] po);
        logic [PO_W-1:0] r;
        for (int i = 0; i < int'(PO_W); i++) begin
            if (i == 0)      r[i] = m[PO_W-1] ^ po[i];
            else if (i == 9) r[i] = m[8] ^ m[PO_W-1] ^ po[i];
            else             r[i] = m[i-1] ^ po[i];
        end
        return r;
    endfunction

    function automatic logic [PO_W-1:0] rand_po();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PO_W-1:0];
    endfunction

    // Starts from IDLE; fault_k selects the pattern whose cut_po[0] is forced to 1 (-1 = none)
    task automatic run_full(input string tag, input int fault_k, input logic [PO_W-1:0] exp_sig,
                            input logic exp_pass);
        bistmode = 1'b1;
        tick();
        chk({tag, "_seed"}, 64'(cut_pi), 64'(seq[0]));
        for (int k = 0; k < int'(NP); k++) begin
            cut_po = (k == fault_k) ? 49'h1 : 49'h0;
            #1;
            chk({tag, "_pat"}, 64'(cut_pi), 64'(seq[k]));
            chk({tag, "_notdone"}, 64'(bistdone), 64'd0);
            tick();
        end
        cut_po = '0;
        chk({tag, "_done"}, 64'(bistdone), 64'd1);
        chk({tag, "_pass"}, 64'(bistpass), 64'(exp_pass));
        chk({tag, "_frozen_pi"}, 64'(cut_pi), 64'(seq[NP]));
        chk({tag, "_sig"}, 64'(dut.misr), 64'(exp_sig));
    endtask

    task automatic to_idle(input string tag);
        bistmode = 1'b0;
        tick();
        pi = 35'h2_468A_CE13;
        #1;
        chk({tag, "_done_clr"}, 64'(bistdone), 64'd0);
        chk({tag, "_pass_clr"}, 64'(bistpass), 64'd0);
        chk({tag, "_pi_thru"}, 64'(cut_pi), 64'(pi));
    endtask

    initial begin
        logic [PO_W-1:0] model;
        logic [PI_W-1:0] held;

        seq[0] = 35'h1;   seq[1] = 35'h2;   seq[2] = 35'h5;   seq[3] = 35'hA;
        seq[4] = 35'h15;  seq[5] = 35'h2A;  seq[6] = 35'h55;  seq[7] = 35'hAA;
        seq[8] = 35'h155;

        rst = 1'b0;
        bistmode = 1'b1;
        cut_po = '0;
        pi = '0;

        // Reset held with bistmode high: outputs low, PIs pass through
        for (int i = 0; i < 4; i++) begin
            tick();
            pi = PI_W'({$urandom, $urandom});
            #1;
            chk("rst_done", 64'(bistdone), 64'd0);
            chk("rst_pass", 64'(bistpass), 64'd0);
            chk("rst_pi", 64'(cut_pi), 64'(pi));
        end

        // Tester flow: release reset with bistmode already high; fault-free run
        rst = 1'b1;
        run_full("clean", -1, 49'h0, 1'b1);

        // Hold in DONE for 20 cycles
        held = cut_pi;
        for (int i = 0; i < 20; i++) begin
            pi = PI_W'($urandom);
            tick();
            if (bistdone !== 1'b1 || bistpass !== 1'b1 || cut_pi !== held)
                chk("hold_stable", {bistdone, bistpass, 27'd0, cut_pi}, {2'b11, 27'd0, held});
        end
        chk("hold_final", {bistdone, bistpass, 27'd0, cut_pi}, {2'b11, 27'd0, held});
        to_idle("hold_exit");

        // Single-bit fault on pattern 3 reaches bit 4 after four more shifts
        run_full("fault", 3, 49'h10, 1'b0);
        to_idle("fault_exit");

        // Abort after 4 RUN edges
        bistmode = 1'b1;
        tick();
        cut_po = 49'h1;
        for (int i = 0; i < 4; i++) tick();
        bistmode = 1'b0;
        tick();
        cut_po = '0;
        #1;
        chk("abort_pi", 64'(cut_pi), 64'(pi));
        chk("abort_misr_clr", 64'(dut.misr), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_nodone", 64'(bistdone), 64'd0);
        run_full("rerun", 3, 49'h10, 1'b0);
        to_idle("rerun_exit");

        // Random responses against the reference MISR
        model = '0;
        bistmode = 1'b1;
        tick();
        for (int k = 0; k < int'(NP); k++) begin
            cut_po = rand_po();
            #1;
            chk("rand_pat", 64'(cut_pi), 64'(seq[k]));
            model = misr_step(model, cut_po);
            tick();
        end
        cut_po = '0;
        chk("rand_done", 64'(bistdone), 64'd1);
        chk("rand_sig", 64'(dut.misr), 64'(model));
        chk("rand_pass", 64'(bistpass), 64'(model == '0));
        to_idle("rand_exit");

        // Reset mid-run
        bistmode = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        #1;
        chk("midrst_out", {bistdone, bistpass}, 2'b00);
        chk("midrst_pi", 64'(cut_pi), 64'(pi));
        rst = 1'b1;
        run_full("after_midrst", -1, 49'h0, 1'b1);

        // Reset in DONE
        rst = 1'b0;
        tick();
        chk("donerst_out", {bistdone, bistpass}, 2'b00);
        chk("donerst_pi", 64'(cut_pi), 64'(pi));
        rst = 1'b1;
        run_full("after_donerst", -1, 49'h0, 1'b1);
        to_idle("final_exit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
